tone_osc_bank: RTL and testbench

//  Multi-voice square-wave oscillator bank for the synth core, 12 MHz clock.

---
 rtl/tone_osc_bank.sv | 123 ++++++++++++
 tb/tb_tone_osc_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tone_osc_bank.sv
// Multi-voice square-wave oscillator bank: per-voice (note, octave) -> period divider,
// free-running period counter with glitch-free retune, and a registered popcount for the mixer.
module tone_osc_bank #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 19,
  // One spare index bit so out-of-range voice numbers stay distinguishable from valid ones.
  localparam int VIDX_W    = $clog2(NUM_VOICES) + 1,
  localparam int MIX_W     = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_valid,
  input  logic [VIDX_W-1:0]     wr_voice,
  input  logic [3:0]            wr_note,
  input  logic [2:0]            wr_octave,
  output logic [NUM_VOICES-1:0] voice_wave,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [MIX_W-1:0]      mix_out
);

  logic             wr_on;
  logic [DIV_W-1:0] wr_base;
  logic [DIV_W-1:0] wr_div;
  logic [MIX_W-1:0] pop;

  // Octave-0 divider for each note at 12 MHz; zero marks a note-off code.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_base = '0;
    case (wr_note)
      4'd1:    wr_base = DIV_W'(366937);
      4'd2:    wr_base = DIV_W'(346342);
      4'd3:    wr_base = DIV_W'(326903);
      4'd4:    wr_base = DIV_W'(308556);
      4'd5:    wr_base = DIV_W'(291238);
      4'd6:    wr_base = DIV_W'(274892);
      4'd7:    wr_base = DIV_W'(259463);
      4'd8:    wr_base = DIV_W'(244901);
      4'd9:    wr_base = DIV_W'(231156);
      4'd10:   wr_base = DIV_W'(218182);
      4'd11:   wr_base = DIV_W'(205936);
      4'd12:   wr_base = DIV_W'(194378);
      4'd13:   wr_base = DIV_W'(183468);
      default: wr_base = '0;
    endcase
  end

  assign wr_on  = (wr_note >= 4'd1) && (wr_note <= 4'd13);
  assign wr_div = wr_base >> wr_octave;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic             pend_flag;
    logic             active;
    logic             wave;
    logic             hit;
    logic             wrap;

    assign hit     = wr_valid && (wr_voice == VIDX_W'(v));
    assign cnt_inc = cnt + 1'b1;
    assign wrap    = active && en && (cnt == div_cur - 1'b1);

    // Retunes of a running voice wait for the wrap so the current period always completes.
    // NOTE: sequential state uses non-blocking assignments so every voice samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        div_cur   <= '0;
        div_pend  <= '0;
        cnt       <= '0;
        pend_flag <= 1'b0;
        active    <= 1'b0;
        wave      <= 1'b0;
      end else if (hit && !wr_on) begin
        active    <= 1'b0;
        cnt       <= '0;
        wave      <= 1'b0;
        pend_flag <= 1'b0;
      end else if (hit && !active) begin
        div_cur   <= wr_div;
        cnt       <= '0;
        active    <= 1'b1;
        wave      <= 1'b1;
        pend_flag <= 1'b0;
      end else if (active && en) begin
        if (wrap) begin
          cnt       <= '0;
          wave      <= 1'b1;
          pend_flag <= 1'b0;
          if (hit)            div_cur <= wr_div;
          else if (pend_flag) div_cur <= div_pend;
        end else begin
          cnt  <= cnt_inc;
          wave <= (cnt_inc < (div_cur >> 1));
          if (hit) begin
            div_pend  <= wr_div;
            pend_flag <= 1'b1;
          end
        end
      end else if (hit) begin
        div_pend  <= wr_div;
        pend_flag <= 1'b1;
      end
    end

    assign voice_wave[v]   = wave;
    assign voice_active[v] = active;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) pop = pop + MIX_W'(voice_wave[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) mix_out <= '0;
    else     mix_out <= pop;
  end

endmodule

// File: tb/tb_tone_osc_bank.sv
// Directed bench for tone_osc_bank: period lengths, glitch-free retune, bypass,
// last-write-wins, note off, enable freeze, mixer popcount and reset.
module tb_tone_osc_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wr_valid;
  logic [2:0] wr_voice;
  logic [3:0] wr_note;
  logic [2:0] wr_octave;
  logic [3:0] voice_wave;
  logic [3:0] voice_active;
  logic [2:0] mix_out;

  int checks = 0;
  int errors = 0;
  int n;

  tone_osc_bank #(.NUM_VOICES(4), .DIV_W(19)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .wr_valid     (wr_valid),
    .wr_voice     (wr_voice),
    .wr_note      (wr_note),
    .wr_octave    (wr_octave),
    .voice_wave   (voice_wave),
    .voice_active (voice_active),
    .mix_out      (mix_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic write_step(input int v, input int note, input int oct);
    wr_valid  = 1'b1;
    wr_voice  = 3'(v);
    wr_note   = 4'(note);
    wr_octave = 3'(oct);
    step();
    wr_valid  = 1'b0;
  endtask

  // Counts consecutive cycles voice 0 stays at lvl, starting from already-seen cycles.
  task automatic run_len(input logic lvl, input int already, output int len);
    len = already;
    while (voice_wave[0] === lvl && len < 5000) begin
      len++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0;
    wr_voice = '0; wr_note = '0; wr_octave = '0;

    // Reset
    step(); step();
    check("rst_wave",   32'(voice_wave),   0);
    check("rst_active", 32'(voice_active), 0);
    check("rst_mix",    32'(mix_out),      0);
    rst = 1'b0;

    // A oct7 -> 1704: high 852, low 852
    en = 1'b1;
    write_step(0, 10, 7);
    check("a_active", 32'(voice_active[0]), 1);
    check("a_wave0",  32'(voice_wave[0]),   1);
    check("a_mix_lag", 32'(mix_out),        0);
    step();
    check("a_mix1", 32'(mix_out), 1);
    run_len(1'b1, 1, n); check("a_high", n, 852);
    run_len(1'b0, 0, n); check("a_low",  n, 852);

    // Retune to C' oct7 (1433) at cnt=100: current period completes first
    repeat (100) step();
    write_step(0, 13, 7);
    run_len(1'b1, 101, n); check("chg_old_high", n, 852);
    run_len(1'b0, 0, n);   check("chg_old_low",  n, 852);
    run_len(1'b1, 0, n);   check("chg_new_high", n, 716);
    run_len(1'b0, 0, n);   check("chg_new_low",  n, 717);

    // Write on the wrap cycle: B oct7 (1518) used immediately
    repeat (1432) step();
    write_step(0, 12, 7);
    run_len(1'b1, 0, n); check("byp_high", n, 759);
    run_len(1'b0, 0, n); check("byp_low",  n, 759);

    // Two writes before wrap: last one (C', 1433) wins
    repeat (10) step();
    write_step(0, 10, 7);
    write_step(0, 13, 7);
    run_len(1'b1, 12, n); check("lw_cur_high", n, 759);
    run_len(1'b0, 0, n);  check("lw_cur_low",  n, 759);
    run_len(1'b1, 0, n);  check("lw_new_high", n, 716);
    run_len(1'b0, 0, n);  check("lw_new_low",  n, 717);

    // Note off mid-high
    repeat (10) step();
    write_step(0, 0, 0);
    check("off_wave",   32'(voice_wave[0]),   0);
    check("off_active", 32'(voice_active[0]), 0);
    check("off_mix_lag", 32'(mix_out), 1);
    step();
    check("off_mix", 32'(mix_out), 0);

    // en low for 50 cycles extends the high phase by exactly 50
    write_step(0, 10, 7);
    check("reload_wave", 32'(voice_wave[0]), 1);
    repeat (100) step();
    en = 1'b0;
    repeat (50) step();
    check("frz_wave", 32'(voice_wave[0]), 1);
    en = 1'b1;
    run_len(1'b1, 150, n); check("frz_high", n, 902);
    run_len(1'b0, 0, n);   check("frz_low",  n, 852);

    // All voices C oct7 (2866) loaded while frozen, then released together
    en = 1'b0;
    write_step(0, 0, 0);
    write_step(0, 1, 7);
    write_step(1, 1, 7);
    write_step(2, 1, 7);
    write_step(3, 1, 7);
    check("mix_active", 32'(voice_active), 4'hF);
    check("mix_wave",   32'(voice_wave),   4'hF);
    step();
    check("mix_four", 32'(mix_out), 4);
    write_step(5, 0, 0);
    check("idx5_ignored", 32'(voice_active), 4'hF);
    en = 1'b1;
    repeat (1432) step();
    check("mix_hi_wave", 32'(voice_wave), 4'hF);
    check("mix_hi_pop",  32'(mix_out),    4);
    step();
    check("mix_lo_wave", 32'(voice_wave), 4'h0);
    check("mix_lo_lag",  32'(mix_out),    4);
    step();
    check("mix_zero", 32'(mix_out), 0);

    // Reset mid-operation with a pending write
    repeat (700) step();
    wr_valid = 1'b1; wr_voice = 3'd1; wr_note = 4'd5; wr_octave = 3'd7;
    rst = 1'b1;
    step();
    wr_valid = 1'b0;
    check("mrst_wave",   32'(voice_wave),   0);
    check("mrst_active", 32'(voice_active), 0);
    check("mrst_mix",    32'(mix_out),      0);
    rst = 1'b0;
    step();
    check("mrst_hold", 32'(voice_active), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
